// File: rtl/uart_rx_inpr.sv
// Serial input port: receives 8N1 frames on rxd into the INPR holding register
// and raises FGI for the CPU; reports overrun (sticky) and framing errors (pulse).
`timescale 1ns/1ps
module uart_rx_inpr #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       fgi_clr,
    output logic [7:0] inpr,
    output logic       fgi,
    output logic       ovr,
    output logic       ferr,
    output logic       busy
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    // Counter runs from 0 after a state entry, so the sample lands on value N-1.
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          rxd_m, rxd_s;
    logic          done_ok, done_bad;

    // Synchroniser presets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        done_ok   = 1'b0;
        done_bad  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxd_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rxd_s, shreg[7:1]};
                    if (bit_idx == 4'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 4'd1;
                end
            end
            STOP: begin
                // Leave on the stop-bit sample so a back-to-back start edge is not missed.
                if (cnt == BIT_LAST) begin
                    cnt_n    = '0;
                    state_n  = IDLE;
                    done_ok  = rxd_s;
                    done_bad = !rxd_s;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    // A completion in the same cycle as fgi_clr takes priority and reloads inpr.
    always_ff @(posedge clk) begin
        if (reset) begin
            inpr <= 8'h00;
            fgi  <= 1'b0;
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ferr <= done_bad;
            if (done_ok && (!fgi || fgi_clr)) begin
                inpr <= shreg;
                fgi  <= 1'b1;
                if (fgi_clr) ovr <= 1'b0;
            end else if (done_ok) begin
                ovr <= 1'b1;
            end else if (fgi_clr) begin
                fgi <= 1'b0;
                ovr <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_inpr.sv
// Directed bench for uart_rx_inpr at 16 clocks per bit: latency, glitch, framing,
// overrun, clear/complete race, break and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx_inpr;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       fgi_clr = 1'b0;
    logic [7:0] inpr;
    logic       fgi, ovr, ferr, busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_inpr #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .fgi_clr(fgi_clr),
        .inpr(inpr), .fgi(fgi), .ovr(ovr), .ferr(ferr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Called on a negedge; the pin goes low immediately, so tf is the next posedge.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic pulse_clr();
        fgi_clr = 1'b1;
        @(negedge clk);
        fgi_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({inpr, fgi, ovr, ferr, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got inpr=%h fgi=%b ovr=%b ferr=%b busy=%b, want all 0",
                     inpr, fgi, ovr, ferr, busy);
        end
    endtask

    task automatic test_valid_byte();
        fork
            send_frame(8'h41, 1'b1);
            begin
                repeat (154) @(negedge clk);   // just after edge tf+153
                n_checks++;
                if (fgi !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL valid_early: got fgi=%b busy=%b, want fgi=0 busy=1", fgi, busy);
                end
                @(negedge clk);                // just after edge tf+154 = S9
                n_checks++;
                if (inpr !== 8'h41 || fgi !== 1'b1) begin
                    n_fail++;
                    $display("FAIL valid_latency: got inpr=%h fgi=%b, want 41 1", inpr, fgi);
                end
                n_checks++;
                if (ovr !== 1'b0 || ferr !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL valid_status: got ovr=%b ferr=%b busy=%b, want 0 0 0", ovr, ferr, busy);
                end
            end
        join
        pulse_clr();
        n_checks++;
        if (fgi !== 1'b0 || inpr !== 8'h41) begin
            n_fail++;
            $display("FAIL valid_clear: got fgi=%b inpr=%h, want 0 41", fgi, inpr);
        end
    endtask

    task automatic test_start_glitch();
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (5) @(negedge clk);             // just after tf+9
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_before_s0: got busy=%b, want 1", busy);
        end
        @(negedge clk);                        // just after S0 = tf+10
        n_checks++;
        if (busy !== 1'b0 || fgi !== 1'b0 || inpr !== 8'h41 || ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_abort: got busy=%b fgi=%b inpr=%h ferr=%b, want 0 0 41 0",
                     busy, fgi, inpr, ferr);
        end
        repeat (2 * CPB) @(negedge clk);
        send_frame(8'hA5, 1'b1);
        n_checks++;
        if (inpr !== 8'hA5 || fgi !== 1'b1 || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_next_frame: got inpr=%h fgi=%b ovr=%b, want a5 1 0", inpr, fgi, ovr);
        end
    endtask

    task automatic test_framing();
        pulse_clr();
        fork
            send_frame(8'h3C, 1'b0);
            begin
                repeat (155) @(negedge clk);   // just after S9
                n_checks++;
                if (ferr !== 1'b1 || fgi !== 1'b0 || inpr !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL framing_pulse: got ferr=%b fgi=%b inpr=%h, want 1 0 a5", ferr, fgi, inpr);
                end
                @(negedge clk);
                n_checks++;
                if (ferr !== 1'b0 || ovr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL framing_one_cycle: got ferr=%b ovr=%b, want 0 0", ferr, ovr);
                end
            end
        join
    endtask

    task automatic test_overrun();
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        n_checks++;
        if (inpr !== 8'h12 || fgi !== 1'b1 || ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got inpr=%h fgi=%b ovr=%b, want 12 1 1", inpr, fgi, ovr);
        end
        pulse_clr();
        n_checks++;
        if (fgi !== 1'b0 || ovr !== 1'b0 || inpr !== 8'h12) begin
            n_fail++;
            $display("FAIL overrun_clear: got fgi=%b ovr=%b inpr=%h, want 0 0 12", fgi, ovr, inpr);
        end
    endtask

    task automatic test_back_to_back_race();
        send_frame(8'h55, 1'b1);
        fork
            send_frame(8'h66, 1'b1);
            begin
                repeat (154) @(negedge clk);   // S9 of 0x66 is the next posedge
                n_checks++;
                if (inpr !== 8'h55 || fgi !== 1'b1 || ovr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL race_before: got inpr=%h fgi=%b ovr=%b, want 55 1 0", inpr, fgi, ovr);
                end
                pulse_clr();
                n_checks++;
                if (inpr !== 8'h66 || fgi !== 1'b1 || ovr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL race_complete_wins: got inpr=%h fgi=%b ovr=%b, want 66 1 0",
                             inpr, fgi, ovr);
                end
            end
        join
    endtask

    task automatic test_break();
        int nferr;
        nferr = 0;
        rxd = 1'b0;
        for (int k = 0; k < 20 * CPB; k++) begin
            @(negedge clk);
            if (ferr === 1'b1) nferr++;
        end
        n_checks++;
        if (nferr !== 2) begin
            n_fail++;
            $display("FAIL break_ferr_count: got %0d ferr pulses, want 2", nferr);
        end
        n_checks++;
        if (inpr !== 8'h66) begin
            n_fail++;
            $display("FAIL break_inpr_kept: got inpr=%h, want 66", inpr);
        end
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL break_recovers: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (80) @(negedge clk);    // past S4 = tf+74
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                n_checks++;
                if ({inpr, fgi, ovr, ferr, busy} !== 12'h000) begin
                    n_fail++;
                    $display("FAIL midreset_state: got inpr=%h fgi=%b ovr=%b ferr=%b busy=%b, want all 0",
                             inpr, fgi, ovr, ferr, busy);
                end
            end
        join
        repeat (20 * CPB) @(negedge clk);
        send_frame(8'h7E, 1'b1);
        n_checks++;
        if (inpr !== 8'h7E || fgi !== 1'b1 || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_recover: got inpr=%h fgi=%b ovr=%b, want 7e 1 0", inpr, fgi, ovr);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        repeat (4) @(negedge clk);
        test_valid_byte();
        repeat (2 * CPB) @(negedge clk);
        test_start_glitch();
        repeat (CPB) @(negedge clk);
        test_framing();
        repeat (2 * CPB) @(negedge clk);
        test_overrun();
        repeat (2 * CPB) @(negedge clk);
        test_back_to_back_race();
        repeat (CPB) @(negedge clk);
        test_break();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
